audio_source_mixer: RTL and testbench

AUDIO_SOURCE_MIXER -- requirements
Module: audio_source_mixer

---
 rtl/audio_pkg.sv | 21 ++
 rtl/sample_hold_bank.sv | 38 +++
 rtl/audio_source_mixer.sv | 164 ++++++++++++++++
 tb/tb_audio_source_mixer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared encodings for the audio source mixer: mode select, FSM states and
// the guard-bit count that sizes the mix accumulator.
package audio_pkg;

    typedef enum logic [1:0] {
        MODE_SELECT = 2'd0,
        MODE_MIX    = 2'd1,
        MODE_MUTE   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SAT   = 2'd2
    } state_e;

    // Three guard bits hold the sum of up to eight full-scale samples.
    localparam int ACC_EXTRA_W = 3;

endpackage

// File: rtl/sample_hold_bank.sv
// Per-channel hold registers fed by the sample strobes, plus a frame snapshot
// so a frame in progress is isolated from newly arriving samples.
module sample_hold_bank #(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_CH*SAMPLE_W-1:0]   sample_i,
    input  logic [NUM_CH-1:0]            valid_i,
    input  logic                         snap_en_i,
    output logic [NUM_CH*SAMPLE_W-1:0]   snap_o
);

    logic [NUM_CH*SAMPLE_W-1:0] hold_q;
    logic [NUM_CH*SAMPLE_W-1:0] snap_q;

    // NOTE: this storage is plain flops, not RAM, so it can and must be reset;
    // a frame started right after reset then mixes zeros, not garbage.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_q <= '0;
            snap_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (valid_i[i]) begin
                    hold_q[i*SAMPLE_W +: SAMPLE_W] <= sample_i[i*SAMPLE_W +: SAMPLE_W];
                end
            end
            if (snap_en_i) begin
                snap_q <= hold_q;
            end
        end
    end

    assign snap_o = snap_q;

endmodule

// File: rtl/audio_source_mixer.sv
// Frame-based audio mixer: on new_frame it snapshots all sources, walks them
// one per cycle (select or sum), then saturates into sample_out.
module audio_source_mixer
    import audio_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_CH*SAMPLE_W-1:0]   sample_in,
    input  logic [NUM_CH-1:0]            sample_valid,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic [1:0]                   mode,
    input  logic [2:0]                   sel,
    input  logic [2:0]                   mix_shift,
    input  logic                         new_frame,
    output logic [SAMPLE_W-1:0]          sample_out,
    output logic                         new_sample_out,
    output logic                         busy,
    output logic                         overrun
);

    localparam int ACC_W = SAMPLE_W + ACC_EXTRA_W;
    localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_EXTRA_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_EXTRA_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    state_e                    state_q, state_d;
    mode_e                     mode_q, mode_d;
    logic [2:0]                sel_q, sel_d;
    logic [2:0]                shift_q, shift_d;
    logic [2:0]                cnt_q, cnt_d;
    logic [NUM_CH-1:0]         en_q, en_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [SAMPLE_W-1:0]       sample_out_q, sample_out_d;
    logic                      new_sample_q, new_sample_d;
    logic                      overrun_q, overrun_d;

    logic                      snap_en;
    logic [NUM_CH*SAMPLE_W-1:0] snap_flat;
    logic signed [SAMPLE_W-1:0] snap_ch [8];
    logic [7:0]                en_ext;
    logic signed [ACC_W-1:0]   shifted;

    sample_hold_bank #(
        .NUM_CH   (NUM_CH),
        .SAMPLE_W (SAMPLE_W)
    ) u_hold (
        .clk       (clk),
        .reset_n   (reset_n),
        .sample_i  (sample_in),
        .valid_i   (sample_valid),
        .snap_en_i (snap_en),
        .snap_o    (snap_flat)
    );

    // Pad to eight lanes so the 3-bit channel counter indexes without truncation.
    for (genvar g = 0; g < 8; g++) begin : g_lane
        if (g < NUM_CH) begin : g_used
            assign snap_ch[g] = snap_flat[g*SAMPLE_W +: SAMPLE_W];
        end else begin : g_pad
            assign snap_ch[g] = '0;
        end
    end

    always_comb begin
        en_ext = '0;
        en_ext[NUM_CH-1:0] = en_q;
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        sel_d        = sel_q;
        shift_d      = shift_q;
        en_d         = en_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        sample_out_d = sample_out_q;
        new_sample_d = 1'b0;
        overrun_d    = overrun_q;
        snap_en      = 1'b0;
        shifted      = (mode_q == MODE_MIX) ? (acc_q >>> shift_q) : acc_q;

        case (state_q)
            ST_IDLE: begin
                if (new_frame) begin
                    snap_en = 1'b1;
                    mode_d  = mode_e'(mode);
                    sel_d   = sel;
                    shift_d = mix_shift;
                    en_d    = ch_enable;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                overrun_d = overrun_q | new_frame;
                if (en_ext[cnt_q]) begin
                    if (mode_q == MODE_MIX) begin
                        acc_d = acc_q + ACC_W'(snap_ch[cnt_q]);
                    end else if (mode_q == MODE_SELECT && cnt_q == sel_q) begin
                        acc_d = ACC_W'(snap_ch[cnt_q]);
                    end
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAST_CH) begin
                    state_d = ST_SAT;
                end
            end
            ST_SAT: begin
                overrun_d = overrun_q | new_frame;
                if (shifted > MAX_V) begin
                    sample_out_d = MAX_V[SAMPLE_W-1:0];
                end else if (shifted < MIN_V) begin
                    sample_out_d = MIN_V[SAMPLE_W-1:0];
                end else begin
                    sample_out_d = shifted[SAMPLE_W-1:0];
                end
                new_sample_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_SELECT;
            sel_q        <= '0;
            shift_q      <= '0;
            en_q         <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
            sample_out_q <= '0;
            new_sample_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            sel_q        <= sel_d;
            shift_q      <= shift_d;
            en_q         <= en_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            sample_out_q <= sample_out_d;
            new_sample_q <= new_sample_d;
            overrun_q    <= overrun_d;
        end
    end

    assign sample_out     = sample_out_q;
    assign new_sample_out = new_sample_q;
    assign busy           = (state_q != ST_IDLE);
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_audio_source_mixer.sv
// Directed bench for audio_source_mixer (NUM_CH=2, SAMPLE_W=16): a vector
// table of single frames plus hand sequences for overrun, reset and snapshot.
module tb_audio_source_mixer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] sample_in;
    logic [1:0]  sample_valid;
    logic [1:0]  ch_enable;
    logic [1:0]  mode;
    logic [2:0]  sel;
    logic [2:0]  mix_shift;
    logic        new_frame;
    logic [15:0] sample_out;
    logic        new_sample_out;
    logic        busy;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    audio_source_mixer #(.NUM_CH(2), .SAMPLE_W(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .ch_enable      (ch_enable),
        .mode           (mode),
        .sel            (sel),
        .mix_shift      (mix_shift),
        .new_frame      (new_frame),
        .sample_out     (sample_out),
        .new_sample_out (new_sample_out),
        .busy           (busy),
        .overrun        (overrun)
    );

    typedef struct {
        logic [15:0] c0;
        logic [15:0] c1;
        logic [1:0]  vld;
        logic [1:0]  en;
        logic [1:0]  md;
        logic [2:0]  sl;
        logic [2:0]  sh;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] c0, input logic [15:0] c1,
                                input logic [1:0] vld, input logic [1:0] en,
                                input logic [1:0] md, input logic [2:0] sl,
                                input logic [2:0] sh, input logic [15:0] exp,
                                input string name);
        vec_t v;
        v.c0 = c0; v.c1 = c1; v.vld = vld; v.en = en; v.md = md;
        v.sl = sl; v.sh = sh; v.exp = exp; v.name = name;
        return v;
    endfunction

    // Observe n cycles; report the first cycle with a pulse and the pulse count.
    task automatic watch(input int n, output int first, output int pulses);
        first  = 0;
        pulses = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (new_sample_out) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
    endtask

    task automatic do_frame(input vec_t v);
        int first, pulses;
        @(negedge clk);
        sample_in    = {v.c1, v.c0};
        sample_valid = v.vld;
        ch_enable    = v.en;
        mode         = v.md;
        sel          = v.sl;
        mix_shift    = v.sh;
        @(negedge clk);
        sample_valid = 2'b00;
        new_frame    = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        check({v.name, "_busy"}, 32'(busy), 32'd1);
        watch(8, first, pulses);
        check({v.name, "_latency"}, 32'(first), 32'd3);
        check({v.name, "_pulses"}, 32'(pulses), 32'd1);
        check({v.name, "_out"}, 32'(sample_out), 32'(v.exp));
        check({v.name, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int first, pulses;

        vecs[0] = mk(16'h0000, 16'h1234, 2'b11, 2'b11, 2'd0, 3'd1, 3'd0, 16'h1234, "sel_ch1");
        vecs[1] = mk(16'h7000, 16'h7000, 2'b11, 2'b11, 2'd1, 3'd0, 3'd0, 16'h7FFF, "mix_pos_clamp");
        vecs[2] = mk(16'h7000, 16'h7000, 2'b11, 2'b11, 2'd1, 3'd0, 3'd1, 16'h7000, "mix_shift1");
        vecs[3] = mk(16'h8000, 16'hFFFF, 2'b11, 2'b11, 2'd1, 3'd0, 3'd0, 16'h8000, "mix_neg_clamp");
        vecs[4] = mk(16'h8000, 16'hFFFF, 2'b11, 2'b01, 2'd1, 3'd0, 3'd0, 16'h8000, "mix_en01");
        vecs[5] = mk(16'h1111, 16'h2222, 2'b11, 2'b11, 2'd0, 3'd5, 3'd0, 16'h0000, "sel_oob");
        vecs[6] = mk(16'h1111, 16'h2222, 2'b11, 2'b11, 2'd2, 3'd0, 3'd0, 16'h0000, "mute");
        vecs[7] = mk(16'h1111, 16'h2222, 2'b11, 2'b11, 2'd3, 3'd1, 3'd0, 16'h0000, "reserved");
        vecs[8] = mk(16'h1111, 16'h2222, 2'b11, 2'b10, 2'd0, 3'd0, 3'd0, 16'h0000, "sel_disabled");
        vecs[9] = mk(16'hFFFC, 16'hFFF8, 2'b11, 2'b11, 2'd1, 3'd0, 3'd2, 16'hFFFD, "mix_asr");

        reset_n = 1'b0; sample_in = '0; sample_valid = '0; ch_enable = '0;
        mode = '0; sel = '0; mix_shift = '0; new_frame = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out", 32'(sample_out), 32'd0);
        check("rst_pulse", 32'(new_sample_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_frame(vecs[i]);
        end
        check("no_overrun_yet", 32'(overrun), 32'd0);

        // Overrun: new_frame held for a second cycle lands in ACCUM and is dropped.
        @(negedge clk);
        sample_in = {16'h0555, 16'h0000}; sample_valid = 2'b11;
        mode = 2'd0; sel = 3'd1; ch_enable = 2'b11;
        @(negedge clk);
        sample_valid = 2'b00; new_frame = 1'b1;
        @(negedge clk);
        @(negedge clk);
        new_frame = 1'b0;
        watch(7, first, pulses);
        check("ovr_latency", 32'(first), 32'd2);
        check("ovr_pulses", 32'(pulses), 32'd1);
        check("ovr_out", 32'(sample_out), 32'h0555);
        check("ovr_flag", 32'(overrun), 32'd1);
        do_frame(mk(16'h0001, 16'h0002, 2'b11, 2'b11, 2'd1, 3'd0, 3'd0, 16'h0003, "ovr_next"));
        check("ovr_sticky", 32'(overrun), 32'd1);

        // Reset in the second ACCUM cycle, with a new_frame on the reset edge.
        @(negedge clk);
        sample_in = {16'h0000, 16'h1111}; sample_valid = 2'b11;
        mode = 2'd1; ch_enable = 2'b01; mix_shift = 3'd0;
        @(negedge clk);
        sample_valid = 2'b00; new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        @(negedge clk);
        reset_n = 1'b0; new_frame = 1'b1;
        @(negedge clk);
        reset_n = 1'b1; new_frame = 1'b0;
        check("abort_out", 32'(sample_out), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_overrun", 32'(overrun), 32'd0);
        watch(6, first, pulses);
        check("abort_pulses", 32'(pulses), 32'd0);
        check("abort_still_idle", 32'(busy), 32'd0);
        check("abort_out_hold", 32'(sample_out), 32'd0);
        do_frame(mk(16'hAAAA, 16'hBBBB, 2'b00, 2'b11, 2'd1, 3'd0, 3'd0, 16'h0000, "hold_cleared"));

        // New samples and control changes during ACCUM only reach the next frame.
        @(negedge clk);
        sample_in = {16'h0200, 16'h0100}; sample_valid = 2'b11;
        mode = 2'd1; ch_enable = 2'b11; mix_shift = 3'd0; sel = 3'd0;
        @(negedge clk);
        sample_valid = 2'b00; new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        sample_in = {16'h2000, 16'h1000}; sample_valid = 2'b11;
        mode = 2'd2; ch_enable = 2'b00; mix_shift = 3'd3;
        @(negedge clk);
        sample_valid = 2'b00;
        watch(7, first, pulses);
        check("snap_latency", 32'(first), 32'd2);
        check("snap_out", 32'(sample_out), 32'h0300);
        do_frame(mk(16'h0000, 16'h0000, 2'b00, 2'b11, 2'd1, 3'd0, 3'd0, 16'h3000, "snap_next"));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
